// File: rtl/usb_buf_pkg.sv
`default_nettype none
// ============================================================================
// usb_buf_pkg - grant encodings and defaults for the USB endpoint buffer arbiter
// Rev 1.0
// ============================================================================
package usb_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_SIE = 2'd1,
    ST_GNT_CPU = 2'd2
  } gnt_state_t;

  localparam int DEFAULT_ADDR_WIDTH = 6;

  localparam logic SEL_SIE = 1'b0;
  localparam logic SEL_CPU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/usb_buf_arbiter.sv
`default_nettype none
// ============================================================================
// usb_buf_arbiter - SIE-priority arbiter for the 8-bit endpoint buffer RAM
// Rev 1.0
// ============================================================================
module usb_buf_arbiter
  import usb_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_WAIT   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sie_req,
  input  logic                  sie_we,
  input  logic [ADDR_WIDTH-1:0] sie_addr,
  input  logic [7:0]            sie_wdata,
  output logic                  sie_ack,
  output logic                  sie_rvalid,
  output logic [7:0]            sie_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_rvalid,
  output logic [7:0]            cpu_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  starve_evt
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  gnt_state_t            r_state;
  gnt_state_t            w_state_nxt;
  logic                  w_starve_nxt;
  logic                  w_sie_elig;
  logic                  w_cpu_elig;
  logic [3:0]            r_wait_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_starve;
  logic                  r_ret_pend;
  logic                  r_ret_sel;
  logic [7:0]            r_sie_rdata;
  logic [7:0]            r_cpu_rdata;

  // A requester acked this cycle sits out the next decision.
  assign w_sie_elig = sie_req && (r_state != ST_GNT_SIE);
  assign w_cpu_elig = cpu_req && (r_state != ST_GNT_CPU);

  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_starve_nxt = 1'b0;
    if (w_sie_elig && w_cpu_elig) begin
      if (r_wait_cnt >= WAIT_LIM) begin
        w_state_nxt  = ST_GNT_CPU;
        w_starve_nxt = 1'b1;
      end else begin
        w_state_nxt  = ST_GNT_SIE;
      end
    end else if (w_sie_elig) begin
      w_state_nxt = ST_GNT_SIE;
    end else if (w_cpu_elig) begin
      w_state_nxt = ST_GNT_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_starve    <= 1'b0;
      r_wait_cnt  <= 4'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_ret_pend  <= 1'b0;
      r_ret_sel   <= SEL_SIE;
      r_sie_rdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;

      case (w_state_nxt)
        ST_GNT_SIE: begin
          r_mem_we    <= sie_we;
          r_mem_addr  <= sie_addr;
          r_mem_wdata <= sie_wdata;
        end
        ST_GNT_CPU: begin
          r_mem_we    <= cpu_we;
          r_mem_addr  <= cpu_addr;
          r_mem_wdata <= cpu_wdata;
        end
        default: ;
      endcase

      if (r_state == ST_GNT_CPU) begin
        r_wait_cnt <= 4'd0;
      end else if (cpu_req && (r_wait_cnt < WAIT_LIM)) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      // Read data arrives from the RAM one cycle after the grant cycle.
      r_ret_pend <= (r_state != ST_IDLE) && !r_mem_we;
      r_ret_sel  <= (r_state == ST_GNT_CPU) ? SEL_CPU : SEL_SIE;

      if (sie_rvalid) r_sie_rdata <= mem_rdata;
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
    end
  end

  always_comb begin
    sie_ack    = (r_state == ST_GNT_SIE);
    cpu_ack    = (r_state == ST_GNT_CPU);
    mem_en     = (r_state != ST_IDLE);
    mem_we     = (r_state != ST_IDLE) && r_mem_we;
    mem_addr   = r_mem_addr;
    mem_wdata  = r_mem_wdata;
    starve_evt = r_starve;
    sie_rvalid = r_ret_pend && (r_ret_sel == SEL_SIE);
    cpu_rvalid = r_ret_pend && (r_ret_sel == SEL_CPU);
    sie_rdata  = sie_rvalid ? mem_rdata : r_sie_rdata;
    cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_buf_arbiter.sv
`default_nettype none
// ============================================================================
// tb_usb_buf_arbiter - directed bench with a behavioural arbitration model
// Rev 1.0
// ============================================================================
module tb_usb_buf_arbiter;

  localparam int AW       = 6;
  localparam int MAX_WAIT = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          sie_req, sie_we, cpu_req, cpu_we;
  logic [AW-1:0] sie_addr, cpu_addr;
  logic [7:0]    sie_wdata, cpu_wdata;
  logic          sie_ack, sie_rvalid, cpu_ack, cpu_rvalid;
  logic [7:0]    sie_rdata, cpu_rdata;
  logic          mem_en, mem_we, starve_evt;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  usb_buf_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .sie_req(sie_req), .sie_we(sie_we), .sie_addr(sie_addr), .sie_wdata(sie_wdata),
    .sie_ack(sie_ack), .sie_rvalid(sie_rvalid), .sie_rdata(sie_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_evt(starve_evt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM driven by the arbiter.
  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Behavioural model: predicts the outputs of the cycle following each edge.
  typedef struct packed { logic cpu; logic [7:0] data; } ret_t;
  ret_t       rq[$];
  ret_t       rr;
  logic [7:0] mmem [64];
  int         m_wait;
  bit         m_ready = 1'b0;
  bit         want_s, want_c, give_s, give_c, m_starve;
  bit         e_sie_ack, e_cpu_ack, e_mem_we, e_starve, e_sie_rv, e_cpu_rv;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_wdata, e_sie_rd, e_cpu_rd;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1'b1;
      rq.delete();
      m_wait = 0;
      {e_sie_ack, e_cpu_ack, e_mem_we, e_starve, e_sie_rv, e_cpu_rv} = '0;
      e_addr = '0; e_wdata = 8'h00; e_sie_rd = 8'h00; e_cpu_rd = 8'h00;
    end else begin
      want_s   = sie_req && !e_sie_ack;
      want_c   = cpu_req && !e_cpu_ack;
      m_starve = want_s && want_c && (m_wait >= MAX_WAIT);
      give_c   = want_c && (!want_s || m_starve);
      give_s   = want_s && !give_c;

      e_sie_rv = 1'b0;
      e_cpu_rv = 1'b0;
      if (rq.size() > 0) begin
        rr = rq.pop_front();
        if (rr.cpu) begin e_cpu_rv = 1'b1; e_cpu_rd = rr.data; end
        else        begin e_sie_rv = 1'b1; e_sie_rd = rr.data; end
      end

      if (e_cpu_ack)    m_wait = 0;
      else if (cpu_req) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;

      e_sie_ack = give_s;
      e_cpu_ack = give_c;
      e_starve  = m_starve;
      e_mem_we  = 1'b0;
      if (give_s || give_c) begin
        e_mem_we = give_c ? cpu_we    : sie_we;
        e_addr   = give_c ? cpu_addr  : sie_addr;
        e_wdata  = give_c ? cpu_wdata : sie_wdata;
        if (e_mem_we) mmem[e_addr] = e_wdata;
        else          rq.push_back('{cpu: give_c, data: mmem[e_addr]});
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("sie_ack", sie_ack, e_sie_ack);
      chk("cpu_ack", cpu_ack, e_cpu_ack);
      chk("mem_en", mem_en, e_sie_ack | e_cpu_ack);
      chk("mem_we", mem_we, e_mem_we);
      chk("starve_evt", starve_evt, e_starve);
      chk("sie_rvalid", sie_rvalid, e_sie_rv);
      chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
      chk("sie_rdata", sie_rdata, e_sie_rd);
      chk("cpu_rdata", cpu_rdata, e_cpu_rd);
      if (e_sie_ack || e_cpu_ack) begin
        chk("mem_addr", mem_addr, e_addr);
        if (e_mem_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic do_req(input bit cpu, input bit we, input logic [AW-1:0] a, input logic [7:0] d);
    bit got = 1'b0;
    if (cpu) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    else     begin sie_we = we; sie_addr = a; sie_wdata = d; sie_req = 1'b1; end
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = cpu ? cpu_ack : sie_ack;
    end
    chk(cpu ? "cpu_req_ack" : "sie_req_ack", got, 1);
    if (cpu) cpu_req = 1'b0; else sie_req = 1'b0;
  endtask

  int  starve_seen;
  bit  got;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]  = 8'(i) ^ 8'h5A;
      mmem[i] = 8'(i) ^ 8'h5A;
    end
    ram[5] = 8'hA5; mmem[5] = 8'hA5;
    mem_rdata = 8'h00;
    reset = 1'b1;
    sie_req = 0; sie_we = 0; sie_addr = '0; sie_wdata = 8'h00;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // SIE read of address 5
    sie_we = 0; sie_addr = 6'h05; sie_req = 1;
    @(negedge clk);
    chk("t1_ack", sie_ack, 1); chk("t1_addr", mem_addr, 6'h05); chk("t1_we", mem_we, 0);
    sie_req = 0;
    @(negedge clk);
    chk("t1_rvalid", sie_rvalid, 1); chk("t1_rdata", sie_rdata, 8'hA5);
    @(negedge clk);
    chk("t1_hold", sie_rdata, 8'hA5);

    // Simultaneous SIE write and CPU read of 0x10
    sie_we = 1; sie_addr = 6'h10; sie_wdata = 8'h3C; sie_req = 1;
    cpu_we = 0; cpu_addr = 6'h10; cpu_req = 1;
    @(negedge clk);
    chk("t2_sie_first", sie_ack, 1); chk("t2_cpu_wait", cpu_ack, 0);
    sie_req = 0;
    @(negedge clk);
    chk("t2_cpu_next", cpu_ack, 1);
    cpu_req = 0;
    @(negedge clk);
    chk("t2_cpu_rdata", cpu_rdata, 8'h3C);
    @(negedge clk);

    // CPU withdrawals while losing to the SIE accumulate wait credit
    starve_seen = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      sie_we = 0; sie_addr = 6'h01; cpu_we = 0; cpu_addr = 6'h02;
      sie_req = 1; cpu_req = 1;
      @(negedge clk);
      chk("t3_round_sie", sie_ack, 1); chk("t3_round_cpu", cpu_ack, 0);
      if (starve_evt) starve_seen++;
      sie_req = 0; cpu_req = 0;
      @(negedge clk);
    end
    sie_req = 1; cpu_req = 1;
    @(negedge clk);
    chk("t3_override_ack", cpu_ack, 1); chk("t3_override_evt", starve_evt, 1);
    if (starve_evt) starve_seen++;
    cpu_req = 0;
    // SIE keeps requesting; CPU must still get through within the bound
    repeat (3) begin @(negedge clk); if (starve_evt) starve_seen++; end
    cpu_addr = 6'h07; cpu_req = 1;
    got = 0;
    for (int k = 0; k < MAX_WAIT + 2 && !got; k++) begin
      @(negedge clk);
      if (starve_evt) starve_seen++;
      got = cpu_ack;
    end
    chk("t3_cpu_latency", got, 1);
    cpu_req = 0;
    repeat (2) begin @(negedge clk); if (starve_evt) starve_seen++; end
    chk("t3_starve_once", starve_seen, 1);
    sie_req = 0;
    repeat (3) @(negedge clk);
    sie_req = 1; cpu_req = 1;
    @(negedge clk);
    chk("t3_wait_cleared", sie_ack, 1);
    sie_req = 0; cpu_req = 0;
    repeat (3) @(negedge clk);

    // CPU back-to-back reads alternate with idle cycles
    cpu_we = 0; cpu_addr = 6'h10; cpu_req = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_alternate", cpu_ack, (k % 2 == 0) ? 1 : 0);
      cpu_addr = cpu_addr + 6'd1;
    end
    cpu_req = 0;
    repeat (2) @(negedge clk);

    // Reset right after a CPU read grant drops the return
    cpu_addr = 6'h10; cpu_req = 1;
    @(negedge clk);
    chk("t5_grant", cpu_ack, 1);
    reset = 1; cpu_req = 0;
    @(negedge clk);
    chk("t5_no_rvalid", cpu_rvalid, 0); chk("t5_mem_en", mem_en, 0);
    chk("t5_cpu_rdata", cpu_rdata, 0); chk("t5_sie_rdata", sie_rdata, 0);
    chk("t5_mem_addr", mem_addr, 0);
    reset = 0;
    @(negedge clk);
    chk("t5_still_quiet", cpu_rvalid, 0);

    // CPU withdraws before being granted while SIE is busy
    sie_we = 0; sie_addr = 6'h03; sie_req = 1;
    cpu_we = 0; cpu_addr = 6'h04; cpu_req = 1;
    @(negedge clk);
    chk("t6_sie_wins", sie_ack, 1);
    cpu_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_cpu", cpu_ack, 0);
    end
    sie_req = 0;
    repeat (2) @(negedge clk);

    // CPU write seen by a later SIE read
    do_req(1'b1, 1'b1, 6'h20, 8'h5A);
    do_req(1'b0, 1'b0, 6'h20, 8'h00);
    @(negedge clk);
    chk("t7_rdata", sie_rdata, 8'h5A);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
